// File: rtl/btn_debounce_if.sv
// Button bundle: raw active-low pins in, debounced level and press/release pulses out.
interface btn_debounce_if #(
  parameter int N = 2
);
  logic [N-1:0] btn_n;
  logic [N-1:0] level;
  logic [N-1:0] pressed_p;
  logic [N-1:0] released_p;

  modport master (output btn_n, input level, pressed_p, released_p);
  modport slave  (input btn_n, output level, pressed_p, released_p);
endinterface

// File: rtl/btn_debounce.sv
// Per-channel 2-flop synchroniser and stable-time debounce FSM with registered outputs.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pressed_p pulses.
module btn_debounce #(
  parameter int N             = 2,
  parameter int DEB_CYCLES    = 240000,
  parameter int REPEAT_DELAY  = 12000000,
  parameter int REPEAT_PERIOD = 2400000
) (
  input  logic          clk,
  input  logic          rst_n,
  btn_debounce_if.slave bus
);
  localparam int CW = ($clog2(DEB_CYCLES) > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_WAIT_DOWN = 2'd1,
    ST_DOWN      = 2'd2,
    ST_WAIT_UP   = 2'd3
  } state_t;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);
`else
  logic w_unused_rpt;
  assign w_unused_rpt = (REPEAT_DELAY != REPEAT_PERIOD);
`endif

  // Preset to released so the channels leave reset idle.
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.btn_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_s;
    logic          w_level_next;
    logic          w_accept_press;
    logic          w_accept_release;
    logic          w_repeat;

    assign w_s = ~r_sync2[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_UP;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_next;
        r_cnt     <= w_cnt_next;
        r_level   <= w_level_next;
        r_press   <= w_accept_press | w_repeat;
        r_release <= w_accept_release;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        ST_UP: begin
          if (w_s) begin
            w_state_next = ST_WAIT_DOWN;
            w_cnt_next   = CW'(1);
          end
        end
        ST_WAIT_DOWN: begin
          if (!w_s) begin
            w_state_next = ST_UP;
            w_cnt_next   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_next = ST_DOWN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_DOWN: begin
          if (!w_s) begin
            w_state_next = ST_WAIT_UP;
            w_cnt_next   = CW'(1);
          end
        end
        ST_WAIT_UP: begin
          if (w_s) begin
            w_state_next = ST_DOWN;
            w_cnt_next   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_next = ST_UP;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = ST_UP;
          w_cnt_next   = '0;
        end
      endcase
    end

    always_comb begin
      w_accept_press   = (r_state == ST_WAIT_DOWN) && (w_state_next == ST_DOWN);
      w_accept_release = (r_state == ST_WAIT_UP) && (w_state_next == ST_UP);
      w_level_next     = (w_state_next == ST_DOWN) || (w_state_next == ST_WAIT_UP);
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] r_rpt;
    logic          r_armed;
    logic          w_held;
    logic          w_rpt_hit;

    assign w_held    = (r_state == ST_DOWN) || (r_state == ST_WAIT_UP);
    assign w_rpt_hit = w_held && (r_rpt == (r_armed ? RPT_PER_LAST : RPT_DLY_LAST));
    // A repeat never coincides with the release pulse of the same channel.
    assign w_repeat  = w_rpt_hit && (w_state_next != ST_UP);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt   <= '0;
        r_armed <= 1'b0;
      end else if (!w_held || (w_state_next == ST_UP)) begin
        r_rpt   <= '0;
        r_armed <= 1'b0;
      end else if (w_rpt_hit) begin
        r_rpt   <= '0;
        r_armed <= 1'b1;
      end else begin
        r_rpt <= r_rpt + 1'b1;
      end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign bus.level[gi]      = r_level;
    assign bus.pressed_p[gi]  = r_press;
    assign bus.released_p[gi] = r_release;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised, self-checking bench for btn_debounce against a run-length reference model.
// Run with BTN_AUTOREPEAT_EN defined to also cover the hold-to-repeat feature.
module tb_btn_debounce;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_debounce_if #(.N(N)) bus ();

  btn_debounce #(
    .N(N), .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pins reach the filter two edges late; a level flips once
  // DEB consecutive samples disagree with it.
  logic [N-1:0] m_h1, m_h2, m_level, m_press, m_rel;
  int m_run  [N];
  int m_held [N];

  task automatic model_reset();
    m_h1    = '1;
    m_h2    = '1;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] pins);
    logic [N-1:0] samp;
    bus.btn_n = pins;
    @(posedge clk);
    samp    = ~m_h2;
    m_h2    = m_h1;
    m_h1    = pins;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < N; c++) begin
      if (samp[c] != m_level[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DEB) begin
        m_level[c] = samp[c];
        m_run[c]   = 0;
        m_held[c]  = 0;
        if (samp[c]) m_press[c] = 1'b1;
        else m_rel[c] = 1'b1;
      end else if (m_level[c]) begin
        m_held[c]++;
`ifdef BTN_AUTOREPEAT_EN
        if (m_held[c] >= RDLY && ((m_held[c] - RDLY) % RPER) == 0) m_press[c] = 1'b1;
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.btn_n = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.level !== '0 || bus.pressed_p !== '0 || bus.released_p !== '0) begin
      bad++;
      $display("FAIL reset_hold got level=%b pressed=%b released=%b want all 0",
               bus.level, bus.pressed_p, bus.released_p);
    end
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step('1);
      total++;
      if (bus.level !== '0 || bus.pressed_p !== '0 || bus.released_p !== '0) begin
        bad++;
        $display("FAIL reset_idle step=%0d got level=%b pressed=%b released=%b want all 0",
                 k, bus.level, bus.pressed_p, bus.released_p);
      end
    end
    $display("test_reset: 100 idle cycles checked");
  endtask

  task automatic test_single_press();
    int first = -1;
    int npress = 0;
    int nrel = 0;
    for (int k = 1; k <= 28; k++) begin
      step((k <= 14) ? 2'b10 : 2'b11);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL single_press step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
      total++;
      if (bus.level[1] !== 1'b0) begin
        bad++;
        $display("FAIL single_press_ch1 step=%0d got level[1]=%b want 0", k, bus.level[1]);
      end
      if (bus.pressed_p[0]) begin
        npress++;
        if (first < 0) first = k;
      end
      if (bus.released_p[0]) nrel++;
    end
    total++;
    if (first !== DEB + 2 || npress !== 1 || nrel !== 1) begin
      bad++;
      $display("FAIL single_press_timing got first=%0d presses=%0d releases=%0d want first=%0d presses=1 releases=1",
               first, npress, nrel, DEB + 2);
    end
    $display("test_single_press: press seen at step %0d", first);
  endtask

  task automatic test_bounce();
    int npulse = 0;
    logic [N-1:0] pins;
    for (int k = 0; k < 50; k++) begin
      pins = '1;
      if (k < 40) pins[0] = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step(pins);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL bounce step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
      if (bus.level[0] || bus.pressed_p[0] || bus.released_p[0]) npulse++;
    end
    total++;
    if (npulse !== 0) begin
      bad++;
      $display("FAIL bounce_reject got %0d active cycles on ch0 want 0", npulse);
    end
    $display("test_bounce: 40 bouncing cycles rejected");
  endtask

  task automatic test_both();
    int nboth = 0;
    int nrel1 = 0;
    int nrel0 = 0;
    for (int k = 1; k <= 40; k++) begin
      step((k <= 20) ? 2'b00 : 2'b10);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL both step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
      if (bus.pressed_p === 2'b11) nboth++;
      if (bus.released_p[1]) nrel1++;
      if (bus.released_p[0]) nrel0++;
    end
    total++;
    if (nboth !== 1 || nrel1 !== 1 || nrel0 !== 0 || bus.level !== 2'b01) begin
      bad++;
      $display("FAIL both_summary got dual_press=%0d rel1=%0d rel0=%0d level=%b want 1 1 0 01",
               nboth, nrel1, nrel0, bus.level);
    end
    for (int k = 0; k < 12; k++) begin
      step('1);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL both_cleanup step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
    end
    $display("test_both: simultaneous press and single release checked");
  endtask

  task automatic test_reset_mid();
    int first = -1;
    int npress = 0;
    int nrel = 0;
    for (int k = 1; k <= 12; k++) step((k <= 8 || k == 12) ? 2'b10 : 2'b11);
    total++;
    if (bus.level[0] !== m_level[0] || m_level[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_setup got level[0]=%b want %b", bus.level[0], m_level[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.level !== '0 || bus.pressed_p !== '0 || bus.released_p !== '0) begin
      bad++;
      $display("FAIL reset_async got level=%b pressed=%b released=%b want all 0",
               bus.level, bus.pressed_p, bus.released_p);
    end
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.released_p !== '0) nrel++;
    end
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(2'b10);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL reset_mid step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
      if (bus.pressed_p[0]) begin
        npress++;
        if (first < 0) first = k;
      end
      if (bus.released_p !== '0) nrel++;
    end
    total++;
    if (first !== DEB + 2 || npress !== 1 || nrel !== 0) begin
      bad++;
      $display("FAIL reset_mid_reaccept got first=%0d presses=%0d releases=%0d want first=%0d presses=1 releases=0",
               first, npress, nrel, DEB + 2);
    end
    for (int k = 0; k < 12; k++) step('1);
    $display("test_reset_mid: re-accepted at step %0d after reset", first);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int want [5] = '{6, 26, 36, 46, 56};
    int got [$];
    int nrel = 0;
    for (int k = 1; k <= 72; k++) begin
      step((k <= 60) ? 2'b10 : 2'b11);
      total++;
      if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
        bad++;
        $display("FAIL autorepeat step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                 k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
      end
      if (bus.pressed_p[0]) got.push_back(k);
      if (bus.released_p[0]) nrel++;
    end
    total++;
    if (got.size() != 5 || nrel !== 1) begin
      bad++;
      $display("FAIL autorepeat_count got presses=%0d releases=%0d want presses=5 releases=1",
               got.size(), nrel);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== want[i]) begin
          bad++;
          $display("FAIL autorepeat_time idx=%0d got step=%0d want step=%0d", i, got[i], want[i]);
        end
      end
    end
    $display("test_autorepeat: %0d presses observed", got.size());
  endtask
`endif

  task automatic test_random();
    int k = 0;
    int npulse = 0;
    int len;
    logic [N-1:0] pins;
    while (k < 400) begin
      pins = N'($urandom);
      len  = $urandom_range(1, 7);
      repeat (len) begin
        step(pins);
        k++;
        total++;
        if (bus.level !== m_level || bus.pressed_p !== m_press || bus.released_p !== m_rel) begin
          bad++;
          $display("FAIL random step=%0d got level=%b pressed=%b released=%b want level=%b pressed=%b released=%b",
                   k, bus.level, bus.pressed_p, bus.released_p, m_level, m_press, m_rel);
        end
        total++;
        if ((bus.pressed_p & bus.released_p) !== '0) begin
          bad++;
          $display("FAIL random_overlap step=%0d got pressed=%b released=%b want no overlap",
                   k, bus.pressed_p, bus.released_p);
        end
        if (|bus.pressed_p || |bus.released_p) npulse++;
      end
    end
    $display("test_random: %0d steps, %0d pulse cycles", k, npulse);
  endtask

  initial begin
    bus.btn_n = '1;
    test_reset();
    test_single_press();
    test_bounce();
    test_both();
    test_reset_mid();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
